// File: rtl/multiport_fifo_pkg.sv
// Shared helpers for multiport_fifo: counter width derivation and the DEPTH sanity check.
package multiport_fifo_pkg;

   // Occupancy/pointer width: address bits plus one wrap-phase bit.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/mp_regfile.sv
// DEPTH x WIDTH storage with WR_PORTS synchronous write and RD_PORTS asynchronous read ports.
module mp_regfile #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned WR_PORTS = 4,
   parameter int unsigned RD_PORTS = 4,
   localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
   input  logic                               clk,
   input  logic [WR_PORTS-1:0]                we,
   input  logic [WR_PORTS-1:0][PTR_W-1:0]     waddr,
   input  logic [WR_PORTS-1:0][WIDTH-1:0]     wdata,
   input  logic [RD_PORTS-1:0][PTR_W-1:0]     raddr,
   output logic [RD_PORTS-1:0][WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write lanes always target distinct addresses, so lane order does not matter.
   always_ff @(posedge clk) begin
      for (int i = 0; i < WR_PORTS; i++) begin
         if (we[i]) mem[waddr[i]] <= wdata[i];
      end
   end

   always_comb begin
      for (int i = 0; i < RD_PORTS; i++) begin
         rdata[i] = mem[raddr[i]];
      end
   end

endmodule

// File: rtl/multiport_fifo.sv
// Multi-port show-ahead synchronous FIFO with all-or-nothing push and saturating pop.
// Optional sticky protocol error flag built when MULTIPORT_FIFO_ERR_EN is defined.
module multiport_fifo
   import multiport_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned WR_PORTS = 4,
   parameter int unsigned RD_PORTS = 4,
   localparam int unsigned PTR_W   = $clog2(DEPTH),
   localparam int unsigned CNT_W   = cnt_width(DEPTH),
   localparam int unsigned WC_W    = $clog2(WR_PORTS + 1),
   localparam int unsigned RC_W    = $clog2(RD_PORTS + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clr,
   input  logic [WC_W-1:0]                 wr_cnt,
   input  logic [WR_PORTS-1:0][WIDTH-1:0]  wr_data,
   output logic                            wr_ready,
   input  logic [RC_W-1:0]                 rd_cnt,
   output logic [RD_PORTS-1:0][WIDTH-1:0]  rd_data,
   output logic [RD_PORTS-1:0]             rd_valid,
   output logic [CNT_W-1:0]                count,
   output logic [CNT_W-1:0]                free_cnt,
   output logic                            err
);

   if (!is_pow2(DEPTH)) begin : g_depth_check
      $error("multiport_fifo: DEPTH must be a power of two");
   end

   logic [CNT_W-1:0]                 w_ptr;
   logic [CNT_W-1:0]                 r_ptr;
   logic                             push_ok;
   logic [CNT_W-1:0]                 pushed;
   logic [CNT_W-1:0]                 popped;
   logic [WR_PORTS-1:0]              we;
   logic [WR_PORTS-1:0][PTR_W-1:0]   waddr;
   logic [RD_PORTS-1:0][PTR_W-1:0]   raddr;

   // Space is judged on the pre-pop occupancy; a same-cycle pop never makes room.
   assign push_ok  = CNT_W'(wr_cnt) <= free_cnt;
   assign wr_ready = push_ok;
   assign pushed   = push_ok ? CNT_W'(wr_cnt) : '0;
   assign popped   = (CNT_W'(rd_cnt) > count) ? count : CNT_W'(rd_cnt);

   always_comb begin
      for (int i = 0; i < WR_PORTS; i++) begin
         we[i]    = push_ok && !clr && !rst && (CNT_W'(i) < CNT_W'(wr_cnt));
         waddr[i] = w_ptr[PTR_W-1:0] + PTR_W'(i);
      end
      for (int i = 0; i < RD_PORTS; i++) begin
         raddr[i]    = r_ptr[PTR_W-1:0] + PTR_W'(i);
         rd_valid[i] = count > CNT_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         w_ptr    <= '0;
         r_ptr    <= '0;
         count    <= '0;
         free_cnt <= CNT_W'(DEPTH);
      end else begin
         w_ptr    <= w_ptr + pushed;
         r_ptr    <= r_ptr + popped;
         count    <= count + pushed - popped;
         free_cnt <= free_cnt - pushed + popped;
      end
   end

`ifdef MULTIPORT_FIFO_ERR_EN
   // Sticky until rst; flush leaves it set so the producer bug stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (!push_ok || (CNT_W'(rd_cnt) > count)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   mp_regfile #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .WR_PORTS (WR_PORTS),
      .RD_PORTS (RD_PORTS)
   ) u_regfile (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wr_data),
      .raddr (raddr),
      .rdata (rd_data)
   );

endmodule
